// File: rtl/register_bank_pkg.sv
// ----------------------------------------------------------------------------
// register_bank_pkg
//   Shared CPU constants used by the general-purpose register file.
//   DATA_WIDTH      : width of one architectural register
//   REG_ADDR_WIDTH  : width of a register index (16 registers)
//   REG_ZERO        : index of the hardwired-zero register
// ----------------------------------------------------------------------------
package register_bank_pkg;

    localparam int DATA_WIDTH     = 32;
    localparam int REG_ADDR_WIDTH = 4;
    localparam int REG_ZERO       = 0;

endpackage : register_bank_pkg

// File: rtl/register_bank.sv
// ----------------------------------------------------------------------------
// register_bank
//   16 x 32-bit general-purpose register file with one shared index port.
//   Register 0 reads as zero and ignores writes. One write per clock; the
//   read path is purely combinational with no write-to-read bypass, so a
//   value written at an edge becomes visible right after that edge.
//
// Ports (positional order is fixed):
//   clk          in   rising-edge clock
//   reset        in   asynchronous, active-high; clears every register
//   dataIn       in   write data
//   dataOut      out  registers[regNum], or 0 when regNum selects register 0
//   regNum       in   shared read/write register index
//   writeEnable  in   1 = write dataIn to registers[regNum] at the next edge
//
// Write protocol: writeEnable is a one-sided strobe. There is no ready
// signal; the register file accepts a write on every rising edge where
// writeEnable is high and reset is low, and never stalls.
// ----------------------------------------------------------------------------
module register_bank
    import register_bank_pkg::*;
#(
    parameter int DATA_WIDTH = register_bank_pkg::DATA_WIDTH,
    parameter int ADDR_WIDTH = register_bank_pkg::REG_ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] dataIn,
    output logic [DATA_WIDTH-1:0] dataOut,
    input  logic [ADDR_WIDTH-1:0] regNum,
    input  logic                  writeEnable
);

    localparam int NUM_REGS = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] ZERO_IDX = ADDR_WIDTH'(REG_ZERO);

    // Architectural storage; kept as a plain array so it can be observed
    // hierarchically by name.
    logic [DATA_WIDTH-1:0] registers [0:NUM_REGS-1];

    // One-hot write select; the zero register is never selected.
    logic [NUM_REGS-1:0] wr_sel;
    logic                idx_is_zero;

    assign idx_is_zero = (regNum == ZERO_IDX);

    always_comb begin
        wr_sel = '0;
        if (writeEnable && !idx_is_zero) begin
            wr_sel[regNum] = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                registers[i] <= '0;
            end
        end else begin
            // Re-assert zero every cycle so register 0 cannot hold anything else.
            registers[0] <= '0;
            for (int i = 1; i < NUM_REGS; i++) begin
                if (wr_sel[i]) begin
                    registers[i] <= dataIn;
                end
            end
        end
    end

    // Read mux: index 0 is forced to zero independently of storage contents.
    assign dataOut = idx_is_zero ? '0 : registers[regNum];

endmodule : register_bank

// File: tb/tb_register_bank.sv
module tb_register_bank;

  localparam int W = 32;
  localparam int A = 4;
  localparam int N = 16;

  // clock / reset block
  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic [W-1:0] data_in = '0;
  logic [W-1:0] data_out;
  logic [A-1:0] reg_num = '0;
  logic         write_enable = 1'b0;

  always #5 clk = ~clk;

  register_bank dut (
    .clk         (clk),
    .reset       (reset),
    .dataIn      (data_in),
    .dataOut     (data_out),
    .regNum      (reg_num),
    .writeEnable (write_enable)
  );

  // scoreboard: expected value, what to observe (-1 = dataOut, else register index), name
  logic [W-1:0] exp_q[$];
  int           tag_q[$];
  string        name_q[$];
  int           checks = 0;
  int           errors = 0;

  task automatic expect_val(input int tag, input logic [W-1:0] exp, input string name);
    exp_q.push_back(exp);
    tag_q.push_back(tag);
    name_q.push_back(name);
  endtask

  // monitor: the DUT output is always presented; sample mid-cycle on negedge
  always @(negedge clk) begin
    while (exp_q.size() > 0) begin
      logic [W-1:0] e;
      logic [W-1:0] act;
      int           t;
      string        n;
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      n = name_q.pop_front();
      act = (t < 0) ? data_out : dut.registers[t];
      checks++;
      if (act !== e) begin
        errors++;
        $display("FAIL %s: got %08h expected %08h", n, act, e);
      end
    end
  end

  // driver tasks: inputs change just after the rising edge
  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic we, input logic [A-1:0] idx, input logic [W-1:0] d);
    write_enable = we;
    reg_num      = idx;
    data_in      = d;
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    #2;
    reset = 1'b0;
  endtask

  initial begin
    // power-on reset
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    drive(1'b0, 4'd0, '0);
    expect_val(-1, 32'h0, "reset_dataout");
    cycle();

    // preload r1..r15 with 0x12345678
    for (int i = 1; i < N; i++) begin
      drive(1'b1, A'(i), 32'h1234_5678);
      cycle();
    end
    drive(1'b0, 4'd9, '0);
    expect_val(9, 32'h1234_5678, "preload_r9");
    expect_val(-1, 32'h1234_5678, "preload_read_r9");
    cycle();

    // asynchronous reset clear, sampled before any rising edge
    reset = 1'b1;
    for (int i = 0; i < N; i++) begin
      expect_val(i, 32'h0, $sformatf("async_reset_r%0d", i));
    end
    expect_val(-1, 32'h0, "async_reset_dataout");
    cycle();
    reset = 1'b0;

    // single write per index, all others stay zero, then read-only hold
    for (int i = 1; i < N; i++) begin
      pulse_reset();
      drive(1'b1, A'(i), 32'hFFFF_FFFF);
      cycle();
      drive(1'b0, A'(i), 32'hF0F0_F0F0);
      for (int j = 0; j < N; j++) begin
        expect_val(j, (j == i) ? 32'hFFFF_FFFF : 32'h0, $sformatf("single_w%0d_r%0d", i, j));
      end
      cycle();
      expect_val(-1, 32'hFFFF_FFFF, $sformatf("hold_read_r%0d", i));
      expect_val(i, 32'hFFFF_FFFF, $sformatf("hold_r%0d", i));
      cycle();
    end

    // register 0 protection
    pulse_reset();
    drive(1'b1, 4'd0, 32'hDEAD_BEEF);
    cycle();
    drive(1'b0, 4'd0, 32'h0);
    expect_val(0, 32'h0, "r0_after_write");
    expect_val(-1, 32'h0, "r0_read");
    expect_val(1, 32'h0, "r0_write_no_spill_r1");
    cycle();

    // reset mid-operation
    drive(1'b1, 4'd7, 32'hA5A5_A5A5);
    cycle();
    drive(1'b0, 4'd7, 32'h0);
    expect_val(7, 32'hA5A5_A5A5, "r7_written");
    cycle();
    reset = 1'b1;
    expect_val(7, 32'h0, "r7_async_clear");
    drive(1'b1, 4'd7, 32'h0000_0001);
    cycle();
    expect_val(7, 32'h0, "r7_write_during_reset");
    expect_val(-1, 32'h0, "r7_read_during_reset");
    cycle();
    reset = 1'b0;                       // released mid-cycle, write still requested
    expect_val(7, 32'h0, "r7_before_edge_after_release");
    cycle();
    drive(1'b0, 4'd7, 32'h0);
    expect_val(7, 32'h0000_0001, "r7_write_after_release");
    cycle();

    // read mux sweep with i * 0x11111111
    for (int i = 0; i < N; i++) begin
      drive(1'b1, A'(i), W'(i) * 32'h1111_1111);
      cycle();
    end
    for (int i = 0; i < N; i++) begin
      drive(1'b0, A'(i), 32'h5555_5555);
      expect_val(-1, (i == 0) ? 32'h0 : W'(i) * 32'h1111_1111, $sformatf("sweep_r%0d", i));
      cycle();
    end

    // no bypass: old value visible until the writing edge
    drive(1'b1, 4'd5, 32'hCAFE_F00D);
    expect_val(-1, 32'h5555_5555, "no_bypass_old");
    cycle();
    drive(1'b0, 4'd5, 32'h0);
    expect_val(-1, 32'hCAFE_F00D, "no_bypass_new");
    expect_val(4, 32'h4444_4444, "neighbor_r4_kept");
    expect_val(6, 32'h6666_6666, "neighbor_r6_kept");
    cycle();

    // drain scoreboard
    cycle();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_register_bank

// File: doc/register_bank.md
Name: register_bank

Overview:
- 16-entry × 32-bit general-purpose register file for the CPU core.
- Single shared address port `regNum`, used for both the write and the read.
- Register 0 is hardwired to zero.
- Sits between the instruction decoder/ALU datapath and the writeback path; one write per clock, read result always available.

Parameters:
- DATA_WIDTH, 32, width of each register and of `dataIn`/`dataOut`.
- ADDR_WIDTH, 4, width of `regNum`; the register count is 2**ADDR_WIDTH = 16.

Ports:
- clk  input  1  system clock; all register updates on the rising edge.
- reset  input  1  asynchronous, active-high; clears every register.
- dataIn  input  32  write data.
- dataOut  output  32  read data for the register selected by `regNum`.
- regNum  input  4  register index for both read and write (0..15).
- writeEnable  input  1  1 = write `dataIn` into `registers[regNum]` at the next rising edge; 0 = read only.
- Port order is fixed exactly as listed, because the instantiation is positional.

Behaviour:
- Storage
  - Internal array named `registers`, indexed 0..15, each DATA_WIDTH bits.
  - The name and indexing are fixed, because benches access `registers[i]` hierarchically.
  - Array elements must be plain variables that the bench can overwrite directly. No extra shadow copies.
- Reset
  - `reset`=1 asynchronously clears `registers[0..15]` to 0, regardless of `clk`.
  - Registers hold 0 while reset stays high; writes are ignored during reset.
  - Deasserting reset mid-cycle has no effect until the next rising edge.
- Write
  - On a rising `clk` edge with `reset`=0, `writeEnable`=1 and `regNum`≠0: `registers[regNum]` ← `dataIn`.
  - All other registers are unchanged.
- Register 0
  - Writes with `regNum`=0 are discarded; `registers[0]` stays 0 at all times.
  - Reading index 0 returns 0.
- Write disabled
  - `writeEnable`=0: no register changes, whatever `dataIn` holds.
- Read
  - Combinational: `dataOut` = `registers[regNum]`, or 0 when `regNum`=0.
  - Zero-cycle latency from a `regNum` change.
  - A written value appears on `dataOut` immediately after the writing edge.
  - Same-cycle read during a write returns the old value until the edge; no bypass.
- Reset value of `dataOut`: 0, since all registers are 0.
- No X propagation: every index 0..15 is valid, so there is no out-of-range case.

Decomposition:
- Shared CPU package holds:
  - constants `DATA_WIDTH`=32 and `REG_ADDR_WIDTH`=4;
  - the `REG_ZERO` index constant (0).
- No sub-module. The write-decode logic and the read mux are inline in `register_bank`.

Test Plan:
- Reset clear: preload all registers with 0x12345678 via hierarchy, assert `reset`=1 without a clock edge -> every `registers[i]` = 0 and `dataOut` = 0.
- Single write, for each i=1..15 (after reset and zeroing): `dataIn`=0xFFFFFFFF, `regNum`=i, `writeEnable`=1, one clock -> `registers[i]`=0xFFFFFFFF and every other index = 0.
- Read-only hold:
  - Follow the single-write step with `writeEnable`=0, `dataIn`=0xF0F0F0F0, one clock.
  - Required: `dataOut`=0xFFFFFFFF and `registers[i]` unchanged.
- Register 0 protection: `regNum`=0, `dataIn`=0xDEADBEEF, `writeEnable`=1, one clock -> `registers[0]`=0 and `dataOut`=0.
- Reset mid-operation:
  - Write 0xA5A5A5A5 to r7.
  - Assert `reset` between clock edges -> r7 = 0 immediately.
  - While reset is high, a write to r7 with 0x1 -> ignored.
- Read mux sweep: write value i×0x11111111 to each ri, then step `regNum` 0..15 -> `dataOut` equals the stored value combinationally, with 0 for index 0.
